// File: rtl/hififo_wr_arbiter.sv
`default_nettype none
// hififo_wr_arbiter: packet-locked round-robin arbiter sharing the pcie_tx wr path among 4 FIFO engines.
// Optional per-channel packet counters under `HIFIFO_WR_ARB_STATS_EN. Rev 1.0
module hififo_wr_arbiter #(
  parameter logic [3:0] ENABLE = 4'b1111,
  parameter int         NCH    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  in_valid,
  output logic [3:0]  in_ready,
  input  logic [65:0] in_data_0,
  input  logic [65:0] in_data_1,
  input  logic [65:0] in_data_2,
  input  logic [65:0] in_data_3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [65:0] out_data,
  output logic [3:0]  grant,
`ifdef HIFIFO_WR_ARB_STATS_EN
  input  logic        stats_clear,
  output logic [15:0] pkt_count_0,
  output logic [15:0] pkt_count_1,
  output logic [15:0] pkt_count_2,
  output logic [15:0] pkt_count_3,
`endif
  output logic        busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  grant_nx;
  logic [1:0]  rr_next, rr_nx;
  logic        out_valid_nx;
  logic [65:0] out_data_nx;

  logic [65:0] data_arr [4];
  logic [65:0] sel_data;
  logic        out_free;
  logic        accept;
  logic        found;
  logic [1:0]  pick;
  logic [1:0]  idx;

  assign data_arr[0] = in_data_0;
  assign data_arr[1] = in_data_1;
  assign data_arr[2] = in_data_2;
  assign data_arr[3] = in_data_3;

  assign out_free = ~out_valid | out_ready;

  for (genvar k = 0; k < NCH; k++) begin : g_ready
    assign in_ready[k] = ENABLE[k] & (state == XFER) & grant[k] & out_free;
  end

  assign accept = |(in_valid & in_ready);
  assign busy   = (state == XFER) | out_valid;

  // grant is one-hot, so an OR of masked words selects the owner's word
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (grant[k]) sel_data = sel_data | data_arr[k];
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_next + 2'(i);
      if (!found && in_valid[idx] && ENABLE[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    grant_nx     = grant;
    rr_nx        = rr_next;
    out_valid_nx = out_valid;
    out_data_nx  = out_data;

    if (accept) begin
      out_valid_nx = 1'b1;
      out_data_nx  = sel_data;
    end else if (out_ready) begin
      out_valid_nx = 1'b0;
    end

    case (state)
      IDLE: begin
        if (found) begin
          grant_nx = 4'b0001 << pick;
          rr_nx    = pick + 2'd1;
          state_nx = XFER;
        end
      end
      XFER: begin
        if (accept && sel_data[65]) begin
          grant_nx = '0;
          state_nx = IDLE;
        end
      end
      default: begin
        grant_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      rr_next   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      rr_next   <= rr_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
    end
  end

`ifdef HIFIFO_WR_ARB_STATS_EN
  logic [15:0] cnt [4];

  // clear takes priority over a same-cycle eof increment
  always_ff @(posedge clock) begin
    if (!reset_n || stats_clear) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else if (accept && sel_data[65]) begin
      for (int k = 0; k < 4; k++) begin
        if (grant[k]) cnt[k] <= cnt[k] + 16'd1;
      end
    end
  end

  assign pkt_count_0 = cnt[0];
  assign pkt_count_1 = cnt[1];
  assign pkt_count_2 = cnt[2];
  assign pkt_count_3 = cnt[3];
`endif

endmodule
`default_nettype wire

// File: tb/tb_hififo_wr_arbiter.sv
`default_nettype none
// Scoreboard bench for hififo_wr_arbiter: random sources, packet-level reference model, decoupled monitor.
module tb_hififo_wr_arbiter;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [65:0] din [4];
  logic        out_valid;
  logic        out_ready;
  logic [65:0] out_data;
  logic [3:0]  grant;
  logic        busy;
  logic        stats_clear;

  logic        reset_b;
  logic [3:0]  in_valid_b;
  logic [3:0]  in_ready_b;
  logic        out_valid_b;
  logic [65:0] out_data_b;
  logic [3:0]  grant_b;
  logic        busy_b;
  logic [65:0] db0, db1, db2, db3;

`ifdef HIFIFO_WR_ARB_STATS_EN
  logic [15:0] pc0, pc1, pc2, pc3;
  logic [15:0] pcb0, pcb1, pcb2, pcb3;
`endif

  hififo_wr_arbiter #(.ENABLE(4'b1111), .NCH(4)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data_0(din[0]), .in_data_1(din[1]), .in_data_2(din[2]), .in_data_3(din[3]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .grant(grant),
`ifdef HIFIFO_WR_ARB_STATS_EN
    .stats_clear(stats_clear), .pkt_count_0(pc0), .pkt_count_1(pc1),
    .pkt_count_2(pc2), .pkt_count_3(pc3),
`endif
    .busy(busy)
  );

  hififo_wr_arbiter #(.ENABLE(4'b1010), .NCH(4)) dut_b (
    .clock(clock), .reset_n(reset_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data_0(db0), .in_data_1(db1), .in_data_2(db2), .in_data_3(db3),
    .out_valid(out_valid_b), .out_ready(1'b1), .out_data(out_data_b), .grant(grant_b),
`ifdef HIFIFO_WR_ARB_STATS_EN
    .stats_clear(1'b0), .pkt_count_0(pcb0), .pkt_count_1(pcb1),
    .pkt_count_2(pcb2), .pkt_count_3(pcb3),
`endif
    .busy(busy_b)
  );

  assign db0 = {2'b11, 64'h0000_0000_0000_00B0};
  assign db1 = {2'b11, 64'h0000_0000_0000_00B1};
  assign db2 = {2'b11, 64'h0000_0000_0000_00B2};
  assign db3 = {2'b11, 64'h0000_0000_0000_00B3};

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 25) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] oh(input int k);
    return 4'b0001 << k;
  endfunction

  // ---------------- sources ----------------
  logic [65:0] src_q [4][$];
  int          vprob [4];
  int          rprob;
  bit          flush_req = 1'b0;
  bit          flush_seen = 1'b0;
  logic [3:0]  hs = 4'b0;
  int          pkt_id = 0;

  task automatic push_pkt(input int ch, input int len, input logic [63:0] fixed, input bit use_fixed);
    logic [31:0] r;
    logic [63:0] pl;
    for (int i = 0; i < len; i++) begin
      r  = $urandom();
      pl = use_fixed ? (fixed + 64'(i)) : {8'(ch), 24'(pkt_id), 8'(i), r[23:0]};
      src_q[ch].push_back({(i == len - 1), (i == 0), pl});
    end
    pkt_id++;
  endtask

  initial begin
    in_valid  = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) din[k] = '0;
    forever begin
      @(posedge clock);
      #2;
      if (flush_req != flush_seen) begin
        for (int k = 0; k < 4; k++) src_q[k].delete();
        flush_seen = flush_req;
      end
      for (int k = 0; k < 4; k++) begin
        bit hold;
        if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        hold = in_valid[k] && !hs[k];
        if (src_q[k].size() == 0) in_valid[k] = 1'b0;
        else if (!hold) in_valid[k] = ($urandom_range(99) < vprob[k]);
        din[k] = (src_q[k].size() > 0) ? src_q[k][0] : '0;
      end
      out_ready = ($urandom_range(99) < rprob);
    end
  end

  // ---------------- reference model ----------------
  // Packet owner, round-robin pointer, and a depth-1 output queue of expected words.
  int          owner = -1;
  int          ptr = 0;
  logic [65:0] sbq [$];
  logic [15:0] mcnt [4];
  bit          started = 1'b0;
  bit          rst_seen = 1'b0;

  always @(posedge clock) begin
    started  = 1'b1;
    rst_seen = !reset_n;
    if (!reset_n) begin
      owner = -1;
      ptr   = 0;
      for (int k = 0; k < 4; k++) mcnt[k] = '0;
    end else begin
      if (owner < 0) begin
        for (int i = 0; i < 4; i++) begin
          if (owner < 0 && in_valid[(ptr + i) % 4]) owner = (ptr + i) % 4;
        end
        if (owner >= 0) ptr = (owner + 1) % 4;
      end else if (in_valid[owner] && sbq.size() == 0) begin
        sbq.push_back(din[owner]);
        if (din[owner][65]) begin
          mcnt[owner] = mcnt[owner] + 16'd1;
          owner = -1;
        end
      end
      if (stats_clear) for (int k = 0; k < 4; k++) mcnt[k] = '0;
    end
  end

  // ---------------- monitor ----------------
  logic [3:0] gseq [$];
  logic [3:0] gprev = '0;

  always @(negedge clock) begin
    if (started) begin
      logic [3:0] exp_ir;
      if (rst_seen) begin
        sbq.delete();
        check("reset_out_data", out_data, '0);
      end
      exp_ir = (owner >= 0 && (sbq.size() == 0 || out_ready)) ? oh(owner) : 4'b0;
      check("in_ready", in_ready, exp_ir);
      check("grant", grant, (owner >= 0) ? oh(owner) : 4'b0);
      check("out_valid", out_valid, sbq.size() != 0);
      check("busy", busy, (owner >= 0) || (sbq.size() != 0));
`ifdef HIFIFO_WR_ARB_STATS_EN
      check("pkt_count_0", pc0, mcnt[0]);
      check("pkt_count_1", pc1, mcnt[1]);
      check("pkt_count_2", pc2, mcnt[2]);
      check("pkt_count_3", pc3, mcnt[3]);
`endif
      if (sbq.size() != 0) begin
        check("out_data", out_data, sbq[0]);
        if (out_ready) void'(sbq.pop_front());
      end
      if (grant !== gprev && grant != 4'b0) gseq.push_back(grant);
      gprev = grant;
    end
    hs = in_valid & in_ready;
  end

  // ---------------- ENABLE=1010 instance ----------------
  logic [3:0] bexp = 4'b0010;
  logic [3:0] bprev = 4'b0;
  int         bcount = 0;

  always @(negedge clock) begin
    if (reset_b) begin
      check("b_in_ready_disabled", in_ready_b & 4'b0101, 4'b0);
      if (grant_b != 4'b0 && bprev == 4'b0) begin
        check("b_grant_order", grant_b, bexp);
        bexp = (bexp == 4'b0010) ? 4'b1000 : 4'b0010;
        bcount++;
      end
      bprev = grant_b;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_drain(input string nm, input int budget);
    int n = 0;
    bit empty = 1'b0;
    while (!empty && n < budget) begin
      @(posedge clock);
      n++;
      empty = (sbq.size() == 0) && (owner < 0);
      for (int k = 0; k < 4; k++) if (src_q[k].size() != 0) empty = 1'b0;
    end
    check(nm, (n < budget), 1'b1);
  endtask

  task automatic wait_grants(input int base, input int need, input int budget);
    int n = 0;
    while (gseq.size() < base + need && n < budget) begin
      @(posedge clock);
      n++;
    end
  endtask

  initial begin
    int base;
    int n;
    logic [3:0] fair_exp [6];
    fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    reset_n     = 1'b0;
    reset_b     = 1'b0;
    in_valid_b  = 4'hF;
    stats_clear = 1'b0;
    rprob       = 100;
    for (int k = 0; k < 4; k++) vprob[k] = 100;

    // fairness: every channel loaded with two 2-word packets, valid held high through reset
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 4; k++) push_pkt(k, 2, 64'h0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    base    = gseq.size();
    reset_n = 1'b1;
    reset_b = 1'b1;
    wait_grants(base, 6, 300);
    check("fair_grant_count", (gseq.size() >= base + 6), 1'b1);
    for (int i = 0; i < 6; i++)
      if (gseq.size() > base + i) check("fair_order", gseq[base + i], fair_exp[i]);
    wait_drain("drain_fair", 500);

    // single channel, 3-word packet with marked payloads
    push_pkt(2, 3, 64'h0123_4567_89AB_CDA0, 1'b1);
    wait_drain("drain_single", 200);

    // backpressure for 5 cycles mid-packet
    push_pkt(0, 6, 64'h0, 1'b0);
    n = 0;
    while (n < 2) begin
      @(negedge clock);
      if (hs[0]) n++;
    end
    @(posedge clock);
    #1 rprob = 0;
    repeat (5) @(posedge clock);
    #1 rprob = 100;
    wait_drain("drain_backpressure", 200);

    // random traffic, random gaps and backpressure
    rprob = 60;
    for (int k = 0; k < 4; k++) vprob[k] = $urandom_range(100, 30);
    for (int p = 0; p < 200; p++) push_pkt($urandom_range(3), $urandom_range(4, 1), 64'h0, 1'b0);
    wait_drain("drain_random", 20000);

    // reset after word 1 of a 4-word packet; next grant must restart at ch0
    rprob = 100;
    for (int k = 0; k < 4; k++) vprob[k] = 100;
    push_pkt(3, 4, 64'h0, 1'b0);
    n = 0;
    while (!hs[3] && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("mid_pkt_wait", (n < 100), 1'b1);
    @(posedge clock);
    #1;
    reset_n   = 1'b0;
    flush_req = ~flush_req;
    repeat (2) @(posedge clock);
    #1;
    for (int k = 3; k >= 0; k--) push_pkt(k, 1, 64'h0, 1'b0);
    base    = gseq.size();
    reset_n = 1'b1;
    wait_grants(base, 1, 100);
    check("post_reset_grant_count", (gseq.size() >= base + 1), 1'b1);
    if (gseq.size() > base) check("post_reset_first_grant", gseq[base], 4'b0001);
    wait_drain("drain_reset", 200);

`ifdef HIFIFO_WR_ARB_STATS_EN
    @(posedge clock);
    #1 stats_clear = 1'b1;
    @(posedge clock);
    #1 stats_clear = 1'b0;
    @(negedge clock);
    check("stats_cleared", {pc0, pc1, pc2, pc3}, 64'h0);
`endif

    check("b_grants_seen", (bcount >= 4), 1'b1);
    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
